// File: rtl/ea_index_seq.sv
// rtl/ea_index_seq.sv - effective-address sequencer driving a registered 9-bit-op ALU
// Forms base+idx8 or pc+rel8 one byte per ALU pass, adding a high-byte pass on page crossing.
module ea_index_seq #(
    parameter bit ALWAYS_FIX = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] base,
    input  logic [7:0]  offset,
    output logic [8:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_c,
    input  logic [7:0]  alu_out,
    input  logic        alu_sumC,
    output logic        busy,
    output logic        done,
    output logic [15:0] ea,
    output logic        page_cross
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_LOR,
        S_HI,
        S_HIR,
        S_DONE
    } state_t;

    localparam logic [8:0] OP_NOP  = 9'h000;
    localparam logic [8:0] OP_ADD  = 9'h010;
    localparam logic [8:0] OP_INC  = 9'h0D0;
    localparam logic [8:0] OP_DEC  = 9'h190;
    localparam logic [8:0] OP_ADD0 = 9'h090;

    state_t      state_q;
    logic        mode_q;
    logic [15:0] base_q;
    logic [7:0]  offset_q;
    logic [15:0] ea_q;
    logic        page_cross_q;
    logic        busy_q;
    logic        done_q;
    logic        cross_d;
    logic        need_hi_d;

    // A branch displacement is signed: a negative offset with no carry out borrows from the high byte.
    always_comb begin
        cross_d   = mode_q ? (alu_sumC ^ offset_q[7]) : alu_sumC;
        need_hi_d = cross_d || (ALWAYS_FIX && !mode_q);
    end

    always_comb begin
        alu_op = OP_NOP;
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        case (state_q)
            S_LO: begin
                alu_op = OP_ADD;
                alu_a  = base_q[7:0];
                alu_b  = offset_q;
            end
            S_HI: begin
                alu_a = base_q[15:8];
                if (!page_cross_q)
                    alu_op = OP_ADD0;
                else if (mode_q && offset_q[7])
                    alu_op = OP_DEC;
                else
                    alu_op = OP_INC;
            end
            default: begin
                alu_op = OP_NOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            base_q       <= 16'h0000;
            offset_q     <= 8'h00;
            ea_q         <= 16'h0000;
            page_cross_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        base_q   <= base;
                        offset_q <= offset;
                        busy_q   <= 1'b1;
                        state_q  <= S_LO;
                    end
                end
                S_LO: begin
                    state_q <= S_LOR;
                end
                S_LOR: begin
                    ea_q[7:0]    <= alu_out;
                    page_cross_q <= cross_d;
                    if (need_hi_d) begin
                        state_q <= S_HI;
                    end else begin
                        ea_q[15:8] <= base_q[15:8];
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end
                end
                S_HI: begin
                    state_q <= S_HIR;
                end
                S_HIR: begin
                    ea_q[15:8] <= alu_out;
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_c      = 1'b0;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ea         = ea_q;
    assign page_cross = page_cross_q;

endmodule
